// File: rtl/par_source_synth_pkg.sv
// Shared constants, mode encodings and FSM state type for the synthetic packet source.
package par_source_synth_pkg;

   localparam int NUM_NODES_DEFAULT = 9;
   localparam int ADDR_BITS         = 4;
   localparam int PAYLOAD_SIZE      = 8;

   localparam int MODE_UNIFORM = 0;
   localparam int MODE_FIXED   = 1;
   localparam int MODE_BITCOMP = 2;

   localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/par_source_synth_lfsr.sv
// Free-running Fibonacci LFSR, x^16+x^14+x^13+x^11+1 when WIDTH=16; an all-zero seed is replaced.
module par_lfsr
   import par_source_synth_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_SEED_DEFAULT)
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] out
);

   // A zero state would lock the register up, so fall back to the default seed.
   localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(LFSR_SEED_DEFAULT) : SEED;

   logic [WIDTH-1:0] lfsr_q;
   logic [WIDTH-1:0] lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[WIDTH-2:0],
                lfsr_q[WIDTH-1] ^ lfsr_q[WIDTH-3] ^ lfsr_q[WIDTH-4] ^ lfsr_q[WIDTH-6]};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr_q <= SEED_EFF;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign out = lfsr_q;

endmodule

// File: rtl/par_source_synth.sv
// Synthetic traffic source: injects {dest, seq} flits into a router local port with valid/busy handshake.
module par_source_synth
   import par_source_synth_pkg::*;
#(
   parameter int          ID          = 0,
   parameter int          NUM_NODES   = NUM_NODES_DEFAULT,
   parameter int          PIR         = 255,
   parameter int          MODE        = 0,
   parameter int          FIXED_DEST  = 0,
   parameter logic [15:0] SEED        = 16'hACE1,
   parameter int          MAX_PACKETS = 0
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              send,
   input  logic                              busy,
   output logic [PAYLOAD_SIZE+ADDR_BITS-1:0] data,
   output logic                              valid,
   output logic [15:0]                       pkt_count,
   output logic [15:0]                       stall_cycles,
   output logic                              done
);

   localparam int DW = PAYLOAD_SIZE + ADDR_BITS;

   // Static destinations are resolved at elaboration; an illegal one disables injection entirely.
   localparam int                   BC_DEST  = (~ID) & ((1 << ADDR_BITS) - 1);
   localparam logic [ADDR_BITS-1:0] FIXED_A  = ADDR_BITS'(FIXED_DEST);
   localparam logic [ADDR_BITS-1:0] BC_A     = ADDR_BITS'(BC_DEST);
   localparam logic                 FIXED_OK = (FIXED_DEST >= 0) && (FIXED_DEST < NUM_NODES) &&
                                               (FIXED_DEST != ID);
   localparam logic                 BC_OK    = (BC_DEST < NUM_NODES) && (BC_DEST != ID);

   logic [15:0]             lfsr;
   logic                    lfsr_unused;
   logic [ADDR_BITS-1:0]    dest;
   logic                    dest_ok;
   logic                    rate_hit;

   state_e                  state_q, state_d;
   logic                    valid_q, valid_d;
   logic [DW-1:0]           data_q, data_d;
   logic [PAYLOAD_SIZE-1:0] seq_q, seq_d;
   logic [15:0]             pkt_count_q, pkt_count_d;
   logic [15:0]             stall_q, stall_d;
   logic [31:0]             accepted_q, accepted_d;

   par_lfsr #(
      .WIDTH (16),
      .SEED  (SEED)
   ) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .out   (lfsr)
   );

   assign lfsr_unused = ^lfsr[15:8+ADDR_BITS];

   always_comb begin
      dest    = lfsr[8 +: ADDR_BITS];
      dest_ok = (32'(dest) < 32'(NUM_NODES)) && (32'(dest) != 32'(ID));
      case (MODE)
         MODE_FIXED: begin
            dest    = FIXED_A;
            dest_ok = FIXED_OK;
         end
         MODE_BITCOMP: begin
            dest    = BC_A;
            dest_ok = BC_OK;
         end
         default: ;
      endcase
      // PIR=0 must never fire, even when the low LFSR byte happens to be zero.
      rate_hit = (PIR != 0) && (32'(lfsr[7:0]) <= 32'(PIR));
   end

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      data_d      = data_q;
      seq_d       = seq_q;
      pkt_count_d = pkt_count_q;
      stall_d     = stall_q;
      accepted_d  = accepted_q;
      case (state_q)
         ST_IDLE: begin
            valid_d = 1'b0;
            if (send && rate_hit && dest_ok) begin
               state_d = ST_HOLD;
               valid_d = 1'b1;
               data_d  = {dest, seq_q};
            end
         end
         ST_HOLD: begin
            if (busy) begin
               stall_d = (stall_q == 16'hFFFF) ? stall_q : stall_q + 16'd1;
            end else begin
               seq_d       = seq_q + 1'b1;
               pkt_count_d = pkt_count_q + 16'd1;
               accepted_d  = accepted_q + 32'd1;
               valid_d     = 1'b0;
               if ((MAX_PACKETS != 0) && (accepted_d == 32'(MAX_PACKETS))) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DONE: begin
            valid_d = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         valid_q     <= 1'b0;
         data_q      <= '0;
         seq_q       <= '0;
         pkt_count_q <= '0;
         stall_q     <= '0;
         accepted_q  <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         data_q      <= data_d;
         seq_q       <= seq_d;
         pkt_count_q <= pkt_count_d;
         stall_q     <= stall_d;
         accepted_q  <= accepted_d;
      end
   end

   assign data         = data_q;
   assign valid        = valid_q;
   assign pkt_count    = pkt_count_q;
   assign stall_cycles = stall_q;
   assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_par_source_synth.sv
// Five differently configured sources run side by side against a cycle-level behavioural model.
module tb_par_source_synth;
   import par_source_synth_pkg::*;

   localparam int NI = 5;
   localparam int DW = PAYLOAD_SIZE + ADDR_BITS;

   int p_id   [NI] = '{0, 4, 2, 1, 0};
   int p_mode [NI] = '{1, 0, 1, 0, 2};
   int p_fd   [NI] = '{5, 0, 7, 0, 0};
   int p_pir  [NI] = '{255, 180, 255, 0, 255};
   int p_max  [NI] = '{0, 0, 3, 0, 0};
   int p_seed [NI] = '{16'hACE1, 16'h1234, 16'hBEEF, 0, 16'h5A5A};
   string nm  [NI] = '{"fix", "uni", "max", "pir0", "bc"};

   typedef struct {
      bit        hold;
      bit        fin;
      bit [15:0] lfsr;
      int        seq;
      int        cnt;
      int        stall;
      int        data;
      int        acc;
   } mdl_t;

   logic          clk = 1'b0;
   logic          rst_r   [NI];
   logic          send_r  [NI];
   logic          busy_r  [NI];
   logic [DW-1:0] data_w  [NI];
   logic          valid_w [NI];
   logic [15:0]   cnt_w   [NI];
   logic [15:0]   stall_w [NI];
   logic          done_w  [NI];

   mdl_t m    [NI];
   bit   dirf [NI];

   int        n_checks = 0;
   int        n_err    = 0;
   bit [15:0] seen     = '0;
   int        pir0_valid = 0;
   int        bc_valid   = 0;
   int        done_cyc   = 0;
   int        max_bad    = 0;
   logic [DW-1:0] held;

   always #5 clk = ~clk;

   par_source_synth #(.ID(0), .NUM_NODES(9), .PIR(255), .MODE(1), .FIXED_DEST(5),
                      .SEED(16'hACE1), .MAX_PACKETS(0)) u_fix (
      .clk(clk), .reset(rst_r[0]), .send(send_r[0]), .busy(busy_r[0]), .data(data_w[0]),
      .valid(valid_w[0]), .pkt_count(cnt_w[0]), .stall_cycles(stall_w[0]), .done(done_w[0]));

   par_source_synth #(.ID(4), .NUM_NODES(9), .PIR(180), .MODE(0), .FIXED_DEST(0),
                      .SEED(16'h1234), .MAX_PACKETS(0)) u_uni (
      .clk(clk), .reset(rst_r[1]), .send(send_r[1]), .busy(busy_r[1]), .data(data_w[1]),
      .valid(valid_w[1]), .pkt_count(cnt_w[1]), .stall_cycles(stall_w[1]), .done(done_w[1]));

   par_source_synth #(.ID(2), .NUM_NODES(9), .PIR(255), .MODE(1), .FIXED_DEST(7),
                      .SEED(16'hBEEF), .MAX_PACKETS(3)) u_max (
      .clk(clk), .reset(rst_r[2]), .send(send_r[2]), .busy(busy_r[2]), .data(data_w[2]),
      .valid(valid_w[2]), .pkt_count(cnt_w[2]), .stall_cycles(stall_w[2]), .done(done_w[2]));

   par_source_synth #(.ID(1), .NUM_NODES(9), .PIR(0), .MODE(0), .FIXED_DEST(0),
                      .SEED(16'h0000), .MAX_PACKETS(0)) u_pir0 (
      .clk(clk), .reset(rst_r[3]), .send(send_r[3]), .busy(busy_r[3]), .data(data_w[3]),
      .valid(valid_w[3]), .pkt_count(cnt_w[3]), .stall_cycles(stall_w[3]), .done(done_w[3]));

   par_source_synth #(.ID(0), .NUM_NODES(9), .PIR(255), .MODE(2), .FIXED_DEST(0),
                      .SEED(16'h5A5A), .MAX_PACKETS(0)) u_bc (
      .clk(clk), .reset(rst_r[4]), .send(send_r[4]), .busy(busy_r[4]), .data(data_w[4]),
      .valid(valid_w[4]), .pkt_count(cnt_w[4]), .stall_cycles(stall_w[4]), .done(done_w[4]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Polynomial x^16+x^14+x^13+x^11+1: the new bit is the parity of the tapped powers.
   function automatic bit [15:0] lfsr_adv(input bit [15:0] v);
      int  taps [4] = '{16, 14, 13, 11};
      bit  fb = 1'b0;
      for (int t = 0; t < 4; t++) fb ^= v[taps[t]-1];
      return {v[14:0], fb};
   endfunction

   function automatic mdl_t mreset(input int k);
      mdl_t r;
      r.hold  = 0;
      r.fin   = 0;
      r.lfsr  = (p_seed[k] == 0) ? 16'hACE1 : 16'(p_seed[k]);
      r.seq   = 0;
      r.cnt   = 0;
      r.stall = 0;
      r.data  = 0;
      r.acc   = 0;
      return r;
   endfunction

   function automatic mdl_t step(input mdl_t mi, input int k, input bit s, input bit b);
      mdl_t r = mi;
      int   dest;
      bit   legal, fire;
      case (p_mode[k])
         0:       dest = int'(mi.lfsr >> 8) % 16;
         1:       dest = p_fd[k];
         default: dest = (~p_id[k]) & 15;
      endcase
      legal = (dest < 9) && (dest != p_id[k]);
      fire  = !mi.hold && !mi.fin && s && (p_pir[k] != 0) && (int'(mi.lfsr % 256) <= p_pir[k]) && legal;
      if (mi.hold) begin
         if (b) begin
            if (r.stall < 65535) r.stall++;
         end else begin
            r.cnt  = (r.cnt + 1) % 65536;
            r.seq  = (r.seq + 1) % 256;
            r.acc++;
            r.hold = 0;
            if (p_max[k] != 0 && r.acc == p_max[k]) r.fin = 1;
         end
      end else if (fire) begin
         r.hold = 1;
         r.data = dest * 256 + r.seq;
      end
      r.lfsr = lfsr_adv(mi.lfsr);
      return r;
   endfunction

   task automatic cmp_inst(input int k);
      check({nm[k], ".valid"}, 32'(valid_w[k]), 32'(m[k].hold));
      check({nm[k], ".data"},  32'(data_w[k]),  32'(m[k].data));
      check({nm[k], ".cnt"},   32'(cnt_w[k]),   32'(m[k].cnt));
      check({nm[k], ".stall"}, 32'(stall_w[k]), 32'(m[k].stall));
      check({nm[k], ".done"},  32'(done_w[k]),  32'(m[k].fin));
   endtask

   task automatic do_cycle();
      logic [3:0] d;
      for (int k = 0; k < NI; k++) begin
         if (!dirf[k]) begin
            send_r[k] = ($urandom_range(0, 3) != 0);
            busy_r[k] = ($urandom_range(0, 9) < 3);
         end
      end
      for (int k = 0; k < NI; k++) begin
         if (rst_r[k]) m[k] = step(m[k], k, send_r[k], busy_r[k]);
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) cmp_inst(k);
      if (valid_w[1]) begin
         d = data_w[1][DW-1:PAYLOAD_SIZE];
         seen[d] = 1'b1;
         check("uni.dest_legal", 32'((d != 4'd4) && (d <= 4'd8)), 32'd1);
      end
      pir0_valid += int'(valid_w[3]);
      bc_valid   += int'(valid_w[4]);
      if (done_w[2]) begin
         done_cyc++;
         if (valid_w[2]) max_bad++;
      end
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         rst_r[k]  = 1'b0;
         send_r[k] = 1'b0;
         busy_r[k] = 1'b0;
         dirf[k]   = 1'b0;
         m[k]      = mreset(k);
      end
      #3;
      for (int k = 0; k < NI; k++) cmp_inst(k);
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) rst_r[k] = 1'b1;

      // Back-to-back fixed-destination traffic: one packet every other cycle.
      dirf[0]   = 1'b1;
      send_r[0] = 1'b1;
      busy_r[0] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         do_cycle();
         if (i % 2 == 0) begin
            check("fix.seq_valid", 32'(valid_w[0]), 32'd1);
            check("fix.seq_data", 32'(data_w[0]), 32'(5 * 256 + i / 2));
         end else begin
            check("fix.gap_valid", 32'(valid_w[0]), 32'd0);
         end
      end
      check("fix.cnt20", 32'(cnt_w[0]), 32'd10);

      // Seven busy cycles with send dropped: the held flit must not move.
      do_cycle();
      held      = data_w[0];
      send_r[0] = 1'b0;
      busy_r[0] = 1'b1;
      for (int i = 0; i < 7; i++) begin
         do_cycle();
         check("fix.hold_valid", 32'(valid_w[0]), 32'd1);
         check("fix.hold_data", 32'(data_w[0]), 32'(held));
      end
      check("fix.stall7", 32'(stall_w[0]), 32'd7);
      busy_r[0] = 1'b0;
      do_cycle();
      check("fix.xfer_valid", 32'(valid_w[0]), 32'd0);
      check("fix.xfer_cnt", 32'(cnt_w[0]), 32'd11);

      // Reset in the middle of a held packet.
      send_r[0] = 1'b1;
      do_cycle();
      check("fix.pre_rst_valid", 32'(valid_w[0]), 32'd1);
      busy_r[0] = 1'b1;
      rst_r[0]  = 1'b0;
      #1;
      check("fix.rst_valid", 32'(valid_w[0]), 32'd0);
      check("fix.rst_cnt", 32'(cnt_w[0]), 32'd0);
      check("fix.rst_data", 32'(data_w[0]), 32'd0);
      m[0] = mreset(0);
      do_cycle();
      rst_r[0]  = 1'b1;
      busy_r[0] = 1'b0;
      do_cycle();
      check("fix.post_rst_data", 32'(data_w[0]), 32'(5 * 256));
      do_cycle();
      check("fix.post_rst_cnt", 32'(cnt_w[0]), 32'd1);

      dirf[0] = 1'b0;
      repeat (2000) do_cycle();

      check("uni.coverage", 32'(seen), 32'h01EF);
      check("pir0.never_valid", 32'(pir0_valid), 32'd0);
      check("bc.never_valid", 32'(bc_valid), 32'd0);
      check("max.done", 32'(done_w[2]), 32'd1);
      check("max.cnt", 32'(cnt_w[2]), 32'd3);
      check("max.done_long", 32'(done_cyc >= 100), 32'd1);
      check("max.valid_in_done", 32'(max_bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
